nios_system_nios2_gen2_1_cpu_ocimem_arbiter: RTL and testbench

Arbitrates the single-port on-chip debug RAM (OCI RAM) between two requesters. The first is JTAG debug, which arrives as take_action/take_no_action pulses and jdo from the debug slave sysclk logic. The second is the CPU-side Avalon-MM debug slave. The block owns the JTAG auto-increment address register, the MonDReg read-data latch and the monitor_ready flag fed back to the debug slave TCK logic.

---
 rtl/nios_system_nios2_gen2_1_cpu_ocimem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_nios_system_nios2_gen2_1_cpu_ocimem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_nios2_gen2_1_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: shares one single-port RAM between the JTAG debug
// command path (one-entry command buffer) and the CPU-side Avalon-MM slave.
module nios_system_nios2_gen2_1_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        CMD_LOAD    = 2'd0,
        CMD_LOAD_RD = 2'd1,
        CMD_RD      = 2'd2,
        CMD_WR      = 2'd3
    } cmd_e;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                rd_jtag_q, rd_jtag_d;
    logic                buf_vld_q, buf_vld_d;
    cmd_e                buf_cmd_q, buf_cmd_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [31:0]         buf_data_q, buf_data_d;
    logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
    logic [31:0]         mon_q, mon_d;
    logic                mon_rdy_q, mon_rdy_d;
    logic                ovr_q, ovr_d;
    logic                last_jtag_q, last_jtag_d;

    logic                cpu_req_s;
    logic                grant_jtag_s;
    logic                grant_cpu_s;
    logic                cpu_done_s;
    logic                ram_rd_s;
    logic                ram_wr_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic [31:0]         ram_wdata_s;
    logic [31:0]         avs_rdata_s;
    logic                unused_jdo_s;

    assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

    // Round-robin: on a tie the requester that was not granted last wins.
    always_comb begin
        cpu_req_s    = avs_read | avs_write;
        grant_jtag_s = (state_q == S_IDLE) & buf_vld_q & (~cpu_req_s | ~last_jtag_q);
        grant_cpu_s  = (state_q == S_IDLE) & cpu_req_s & ~grant_jtag_s;
    end

    // Next-state, RAM port and command-buffer capture logic.
    always_comb begin
        state_d     = state_q;
        rd_jtag_d   = rd_jtag_q;
        buf_vld_d   = buf_vld_q;
        buf_cmd_d   = buf_cmd_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        jtag_addr_d = jtag_addr_q;
        mon_d       = mon_q;
        mon_rdy_d   = mon_rdy_q;
        ovr_d       = ovr_q;
        last_jtag_d = last_jtag_q;
        ram_rd_s    = 1'b0;
        ram_wr_s    = 1'b0;
        ram_addr_s  = jtag_addr_q;
        ram_wdata_s = buf_data_q;
        avs_rdata_s = 32'd0;
        cpu_done_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_jtag_s) begin
                    last_jtag_d = 1'b1;
                    buf_vld_d   = 1'b0;
                    case (buf_cmd_q)
                        CMD_LOAD: begin
                            jtag_addr_d = buf_addr_q;
                        end
                        CMD_LOAD_RD: begin
                            ram_addr_s  = buf_addr_q;
                            ram_rd_s    = 1'b1;
                            jtag_addr_d = buf_addr_q;
                            mon_rdy_d   = 1'b0;
                            rd_jtag_d   = 1'b1;
                            state_d     = S_RD_WAIT;
                        end
                        CMD_RD: begin
                            ram_rd_s    = 1'b1;
                            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
                            mon_rdy_d   = 1'b0;
                            rd_jtag_d   = 1'b1;
                            state_d     = S_RD_WAIT;
                        end
                        CMD_WR: begin
                            ram_wr_s    = 1'b1;
                            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
                        end
                        default: begin
                            buf_vld_d = 1'b0;
                        end
                    endcase
                end else if (grant_cpu_s) begin
                    last_jtag_d = 1'b0;
                    ram_addr_s  = avs_address;
                    if (avs_read) begin
                        ram_rd_s  = 1'b1;
                        rd_jtag_d = 1'b0;
                        state_d   = S_RD_WAIT;
                    end else begin
                        ram_wr_s    = 1'b1;
                        ram_wdata_s = avs_writedata;
                        cpu_done_s  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                state_d = S_IDLE;
                if (rd_jtag_q) begin
                    mon_d     = ram_rdata;
                    mon_rdy_d = 1'b1;
                end else begin
                    avs_rdata_s = ram_rdata;
                    cpu_done_s  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A pulse is accepted when the buffer is empty or frees this cycle.
        if (take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a) begin
            if (!buf_vld_d) begin
                buf_vld_d  = 1'b1;
                buf_addr_d = jdo[ADDR_W+7:8];
                buf_data_d = jdo[34:3];
                if (take_action_ocimem_b) begin
                    buf_cmd_d = CMD_WR;
                end else if (take_action_ocimem_a) begin
                    buf_cmd_d = jdo[34] ? CMD_LOAD_RD : CMD_LOAD;
                    ovr_d     = 1'b0;
                end else begin
                    buf_cmd_d = CMD_RD;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            ovr_d = ovr_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_jtag_q   <= 1'b0;
            buf_vld_q   <= 1'b0;
            buf_cmd_q   <= CMD_LOAD;
            buf_addr_q  <= '0;
            buf_data_q  <= 32'd0;
            jtag_addr_q <= '0;
            mon_q       <= 32'd0;
            mon_rdy_q   <= 1'b1;
            ovr_q       <= 1'b0;
            last_jtag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_jtag_q   <= rd_jtag_d;
            buf_vld_q   <= buf_vld_d;
            buf_cmd_q   <= buf_cmd_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            jtag_addr_q <= jtag_addr_d;
            mon_q       <= mon_d;
            mon_rdy_q   <= mon_rdy_d;
            ovr_q       <= ovr_d;
            last_jtag_q <= last_jtag_d;
        end
    end

    // Reset suppresses RAM accesses and any CPU completion in the same cycle.
    always_comb begin
        ram_rd          = ram_rd_s & ~reset;
        ram_wr          = ram_wr_s & ~reset;
        ram_addr        = ram_addr_s;
        ram_wdata       = ram_wdata_s;
        avs_readdata    = reset ? 32'd0 : avs_rdata_s;
        avs_waitrequest = cpu_req_s & ~(cpu_done_s & ~reset);
        MonDReg         = mon_q;
        monitor_ready   = mon_rdy_q;
        jtag_overrun    = ovr_q;
    end

endmodule

// File: tb/tb_nios_system_nios2_gen2_1_cpu_ocimem_arbiter.sv
// Directed vector bench for the OCI RAM arbiter; a behavioural RAM model
// answers ram_rd with one cycle of latency.
module tb_nios_system_nios2_gen2_1_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready, jtag_overrun;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_rd, ram_wr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios_system_nios2_gen2_1_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .jdo(jdo), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
        .jtag_overrun(jtag_overrun),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM model: unwritten words read back as 0x5A0000<addr>.
    logic [31:0] mem [256];
    logic        mem_vld [256];
    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr]     <= ram_wdata;
            mem_vld[ram_addr] <= 1'b1;
        end
        if (ram_rd) begin
            ram_rdata <= mem_vld[ram_addr] ? mem[ram_addr] : (32'h5A00_0000 | {24'd0, ram_addr});
        end
    end

    typedef struct {
        string       name;
        logic [3:0]  ctl;   // {reset, ta_a, tna_a, ta_b}
        logic [37:0] jdo;
        logic [1:0]  rw;    // {avs_read, avs_write}
        logic [7:0]  a;
        logic [31:0] wd;
        logic [1:0]  erw;   // expected {ram_rd, ram_wr}
        logic [7:0]  ea;
        logic [31:0] ewd;
        logic        ew;
        logic [31:0] erd;
        logic [31:0] emon;
        logic [1:0]  emo;   // expected {monitor_ready, jtag_overrun}
    } vec_t;

    function automatic vec_t mk(string n, logic [3:0] ctl, logic [37:0] j, logic [1:0] rw,
                                logic [7:0] a, logic [31:0] wd, logic [1:0] erw, logic [7:0] ea,
                                logic [31:0] ewd, logic ew, logic [31:0] erd, logic [31:0] emon,
                                logic [1:0] emo);
        vec_t v;
        v.name = n; v.ctl = ctl; v.jdo = j; v.rw = rw; v.a = a; v.wd = wd;
        v.erw = erw; v.ea = ea; v.ewd = ewd; v.ew = ew; v.erd = erd; v.emon = emon; v.emo = emo;
        return v;
    endfunction

    function automatic logic [37:0] ja(logic [7:0] a, logic rdf);
        return ({37'd0, rdf} << 34) | ({30'd0, a} << 8);
    endfunction

    function automatic logic [37:0] jw(logic [31:0] d);
        return {3'd0, d, 3'd0};
    endfunction

    localparam logic [37:0] J0 = 38'd0;

    task automatic run(input vec_t v);
        logic ok;
        logic [31:0] wd_act, wd_exp;
        logic [7:0]  a_act, a_exp;
        logic [31:0] rd_act, rd_exp;
        {reset, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b} = v.ctl;
        jdo = v.jdo;
        {avs_read, avs_write} = v.rw;
        avs_address = v.a;
        avs_writedata = v.wd;
        @(negedge clk);
        a_act  = (v.erw != 2'b00) ? ram_addr : 8'd0;
        a_exp  = (v.erw != 2'b00) ? v.ea : 8'd0;
        wd_act = v.erw[0] ? ram_wdata : 32'd0;
        wd_exp = v.erw[0] ? v.ewd : 32'd0;
        rd_act = ((v.rw[1] & ~v.ew) | v.ctl[3]) ? avs_readdata : 32'd0;
        rd_exp = ((v.rw[1] & ~v.ew) | v.ctl[3]) ? v.erd : 32'd0;
        ok = ({ram_rd, ram_wr} == v.erw) && (a_act == a_exp) && (wd_act == wd_exp) &&
             (avs_waitrequest == v.ew) && (rd_act == rd_exp) && (MonDReg == v.emon) &&
             ({monitor_ready, jtag_overrun} == v.emo);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got rd/wr=%b addr=%h wdata=%h wait=%b rdata=%h mon=%h rdy/ovr=%b ; want rd/wr=%b addr=%h wdata=%h wait=%b rdata=%h mon=%h rdy/ovr=%b",
                     v.name, {ram_rd, ram_wr}, a_act, wd_act, avs_waitrequest, rd_act, MonDReg,
                     {monitor_ready, jtag_overrun}, v.erw, a_exp, wd_exp, v.ew, rd_exp, v.emon, v.emo);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(mk("rst_out",   4'b1000, J0, 2'b10, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b1, 32'h0, 32'h0, 2'b10));
        tbl.push_back(mk("ld10",      4'b0100, ja(8'h10, 1'b0), 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        tbl.push_back(mk("wrA5_p",    4'b0001, jw(32'hA5A5A5A5), 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        tbl.push_back(mk("wrA5",      4'b0001, jw(32'h1), 2'b00, 8'h00, 32'h0, 2'b01, 8'h10, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, 2'b10));
        tbl.push_back(mk("wr1",       4'b0001, jw(32'h2), 2'b00, 8'h00, 32'h0, 2'b01, 8'h11, 32'h1, 1'b0, 32'h0, 32'h0, 2'b10));
        tbl.push_back(mk("wr2",       4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b01, 8'h12, 32'h2, 1'b0, 32'h0, 32'h0, 2'b10));
        tbl.push_back(mk("rd13_p",    4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        tbl.push_back(mk("rd13_g",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h13, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        tbl.push_back(mk("rd13_w",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00));
        tbl.push_back(mk("ldrd11",    4'b0100, ja(8'h11, 1'b1), 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000013, 2'b10));
        tbl.push_back(mk("ldrd11_g",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h11, 32'h0, 1'b0, 32'h0, 32'h5A000013, 2'b10));
        tbl.push_back(mk("ldrd11_w",  4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000013, 2'b00));
        tbl.push_back(mk("rd11_g",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h11, 32'h0, 1'b0, 32'h0, 32'h1, 2'b10));
        tbl.push_back(mk("rd11_w",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h1, 2'b00));
        tbl.push_back(mk("rd12_p",    4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h1, 2'b10));
        tbl.push_back(mk("rd12_g",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h12, 32'h0, 1'b0, 32'h0, 32'h1, 2'b10));
        tbl.push_back(mk("rd12_w",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h1, 2'b00));
        tbl.push_back(mk("ldFF",      4'b0100, ja(8'hFF, 1'b0), 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h2, 2'b10));
        tbl.push_back(mk("wrFF_p",    4'b0001, jw(32'hCAFEF00D), 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h2, 2'b10));
        tbl.push_back(mk("wrFF",      4'b0001, jw(32'h12345678), 2'b00, 8'h00, 32'h0, 2'b01, 8'hFF, 32'hCAFEF00D, 1'b0, 32'h0, 32'h2, 2'b10));
        tbl.push_back(mk("wr00_wrap", 4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b01, 8'h00, 32'h12345678, 1'b0, 32'h0, 32'h2, 2'b10));
        tbl.push_back(mk("rd01_p",    4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h2, 2'b10));
        tbl.push_back(mk("rd01_g",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h01, 32'h0, 1'b0, 32'h0, 32'h2, 2'b10));
        tbl.push_back(mk("rd01_w",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h2, 2'b00));
        tbl.push_back(mk("ldrd00",    4'b0100, ja(8'h00, 1'b1), 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000001, 2'b10));
        tbl.push_back(mk("ldrd00_g",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000001, 2'b10));
        tbl.push_back(mk("ldrd00_w",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000001, 2'b00));
        tbl.push_back(mk("wrap_chk",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h12345678, 2'b10));
        tbl.push_back(mk("cpu_wr",    4'b0000, J0, 2'b01, 8'h20, 32'h0BADF00D, 2'b01, 8'h20, 32'h0BADF00D, 1'b0, 32'h0, 32'h12345678, 2'b10));
        tbl.push_back(mk("cpu_rd",    4'b0000, J0, 2'b10, 8'h20, 32'h0, 2'b10, 8'h20, 32'h0, 1'b1, 32'h0, 32'h12345678, 2'b10));
        tbl.push_back(mk("cpu_rd_dn", 4'b0000, J0, 2'b10, 8'h20, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0BADF00D, 32'h12345678, 2'b10));
        tbl.push_back(mk("idle",      4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h12345678, 2'b10));

        {reset, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b} = 4'b1000;
        jdo = J0; {avs_read, avs_write} = 2'b00; avs_address = 8'h00; avs_writedata = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        // Tie-break after reset: JTAG first, then CPU, then JTAG again only after a CPU grant.
        run(mk("tie_rst0", 4'b1000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h12345678, 2'b10));
        run(mk("tie_rst1", 4'b1000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        run(mk("tieA_p",   4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        run(mk("tieA_jt",  4'b0000, J0, 2'b10, 8'h12, 32'h0, 2'b10, 8'h00, 32'h0, 1'b1, 32'h0, 32'h0, 2'b10));
        run(mk("tieA_w",   4'b0000, J0, 2'b10, 8'h12, 32'h0, 2'b00, 8'h00, 32'h0, 1'b1, 32'h0, 32'h0, 2'b00));
        run(mk("tieA_cpu", 4'b0000, J0, 2'b10, 8'h12, 32'h0, 2'b10, 8'h12, 32'h0, 1'b1, 32'h0, 32'h12345678, 2'b10));
        run(mk("tieA_dn",  4'b0000, J0, 2'b10, 8'h12, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h2, 32'h12345678, 2'b10));
        run(mk("tieB_p",   4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h12345678, 2'b10));
        run(mk("tieB_jt",  4'b0010, J0, 2'b01, 8'h30, 32'h11112222, 2'b10, 8'h01, 32'h0, 1'b1, 32'h0, 32'h12345678, 2'b10));
        run(mk("tieB_w",   4'b0000, J0, 2'b01, 8'h30, 32'h11112222, 2'b00, 8'h00, 32'h0, 1'b1, 32'h0, 32'h12345678, 2'b00));
        run(mk("tieC_cpu", 4'b0000, J0, 2'b01, 8'h30, 32'h11112222, 2'b01, 8'h30, 32'h11112222, 1'b0, 32'h0, 32'h5A000001, 2'b10));
        run(mk("tieC_jt",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h02, 32'h0, 1'b0, 32'h0, 32'h5A000001, 2'b10));
        run(mk("tieC_w",   4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000001, 2'b00));

        // Overrun: second pulse lands while a CPU read holds the RAM.
        run(mk("ovr_p1",   4'b0010, J0, 2'b10, 8'h12, 32'h0, 2'b10, 8'h12, 32'h0, 1'b1, 32'h0, 32'h5A000002, 2'b10));
        run(mk("ovr_p2",   4'b0010, J0, 2'b10, 8'h12, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h2, 32'h5A000002, 2'b10));
        run(mk("ovr_set",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h03, 32'h0, 1'b0, 32'h0, 32'h5A000002, 2'b11));
        run(mk("ovr_w",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000002, 2'b01));
        run(mk("ovr_hold", 4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000003, 2'b11));
        run(mk("ovr_rd4",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h04, 32'h0, 1'b0, 32'h0, 32'h5A000003, 2'b11));
        run(mk("ovr_clrp", 4'b0100, ja(8'h05, 1'b0), 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000003, 2'b01));
        run(mk("ovr_clr",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000004, 2'b10));

        // Reset while a JTAG read is in RD_WAIT abandons it.
        run(mk("rrw_p",    4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000004, 2'b10));
        run(mk("rrw_g",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h05, 32'h0, 1'b0, 32'h0, 32'h5A000004, 2'b10));
        run(mk("rrw_rst",  4'b1000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h5A000004, 2'b00));
        run(mk("rrw_post", 4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        run(mk("rrw_p2",   4'b0010, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        run(mk("rrw_addr", 4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b10, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b10));
        run(mk("rrw_w",    4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00));
        run(mk("rrw_mon",  4'b0000, J0, 2'b00, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0, 32'h0, 32'h12345678, 2'b10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
